// File: rtl/mul_arbiter.sv
// mul_arbiter: two valid/ready requesters share one combinational
// N-bit unsigned multiplier; results return tagged with requester id.
// Ports: clk, rst (sync, active high); reqX_valid/ready/rs1/rs2;
// res_valid, res_ready, res_id, res_data (2N bits); busy.

module mul_unit #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
endmodule

module mul_arbiter #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_rs1,
  input  logic [N-1:0]   req0_rs2,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_rs1,
  input  logic [N-1:0]   req1_rs2,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           res_id,
  output logic [2*N-1:0] res_data,
  output logic           busy
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           last_grant;
  logic           pend_id;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [2*N-1:0] prod;
  logic           grant0;
  logic           grant1;

  mul_unit #(.N(N)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          grant0 = req0_valid &
                   (!req1_valid | last_grant);
          grant1 = req1_valid &
                   (!req0_valid | !last_grant);
        end
        if (grant0 | grant1) state_nxt = CALC;
      end
      CALC: state_nxt = HOLD;
      HOLD: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE) & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      pend_id    <= 1'b0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
    end else begin
      if (grant0 | grant1) begin
        op_a       <= grant1 ? req1_rs1 : req0_rs1;
        op_b       <= grant1 ? req1_rs2 : req0_rs2;
        pend_id    <= grant1;
        last_grant <= grant1;
      end
      if (state == CALC) begin
        res_data  <= prod;
        res_id    <= pend_id;
        res_valid <= 1'b1;
      end
      if (state == HOLD && res_ready)
        res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed scenarios plus random traffic for
// mul_arbiter, checked against a transaction-level reference model.
module tb_mul_arbiter;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid;
  logic           req0_ready;
  logic [N-1:0]   req0_rs1;
  logic [N-1:0]   req0_rs2;
  logic           req1_valid;
  logic           req1_ready;
  logic [N-1:0]   req1_rs1;
  logic [N-1:0]   req1_rs2;
  logic           res_valid;
  logic           res_ready;
  logic           res_id;
  logic [2*N-1:0] res_data;
  logic           busy;

  always #5 clk = ~clk;

  mul_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rs1   (req0_rs1),
    .req0_rs2   (req0_rs2),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rs1   (req1_rs1),
    .req1_rs2   (req1_rs2),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_data   (res_data),
    .busy       (busy)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: one job in flight, aged in cycles since grant.
  bit             m_job  = 1'b0;
  int             m_age  = 0;
  bit             m_last = 1'b1;
  bit             m_id   = 1'b0;
  logic [2*N-1:0] m_prod = '0;
  logic [2*N-1:0] m_data = '0;
  bit             m_rid  = 1'b0;

  task automatic chk1(string tag, logic obs, logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(string tag, logic [2*N-1:0] obs,
                      logic [2*N-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*N-1:0] mul(logic [N-1:0] a,
                                         logic [N-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*N-1:0];
  endfunction

  // -1: nobody granted this cycle
  function automatic int exp_grant();
    if (rst || m_job) return -1;
    if (req0_valid && req1_valid) return (m_last == 1'b1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic check_outputs();
    int g;
    g = exp_grant();
    chk1("req0_ready", req0_ready, g == 0);
    chk1("req1_ready", req1_ready, g == 1);
    chk1("busy", busy, m_job && !rst);
    chk1("res_valid", res_valid, m_job && m_age >= 2);
    chkd("res_data", res_data, m_data);
    chk1("res_id", res_id, m_rid);
  endtask

  task automatic update_model();
    int g;
    g = exp_grant();
    if (rst) begin
      m_job  = 1'b0;
      m_last = 1'b1;
      m_data = '0;
      m_rid  = 1'b0;
    end else if (m_job) begin
      if (m_age == 1) begin
        m_age  = 2;
        m_data = m_prod;
        m_rid  = m_id;
      end else if (res_ready) begin
        m_job = 1'b0;
      end
    end else if (g >= 0) begin
      m_job  = 1'b1;
      m_age  = 1;
      m_id   = (g == 1);
      m_last = (g == 1);
      m_prod = (g == 1) ? mul(req1_rs1, req1_rs2)
                        : mul(req0_rs1, req0_rs2);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    int ids[$];
    int at[$];

    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_rs1   = '0;
    req0_rs2   = '0;
    req1_rs1   = '0;
    req1_rs2   = '0;
    res_ready  = 1'b0;
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b0;
    chk1("rst_res_valid", res_valid, 1'b0);
    chkd("rst_res_data", res_data, '0);
    chk1("rst_res_id", res_id, 1'b0);

    // req0 alone: 3*5
    req0_valid = 1'b1;
    req0_rs1   = 16'd3;
    req0_rs2   = 16'd5;
    #1;
    chk1("r037_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk1("r037_valid", res_valid, 1'b1);
    chkd("r037_data", res_data, 32'h0000000F);
    chk1("r037_id", res_id, 1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();

    // req1 alone: full-width product
    req1_valid = 1'b1;
    req1_rs1   = 16'hFFFF;
    req1_rs2   = 16'hFFFF;
    tick();
    req1_valid = 1'b0;
    tick();
    chkd("r038_data", res_data, 32'hFFFE0001);
    chk1("r038_id", res_id, 1'b1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // both held valid from reset, consumer always ready
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    req0_valid = 1'b1;
    req0_rs1   = 16'd2;
    req0_rs2   = 16'd3;
    req1_valid = 1'b1;
    req1_rs1   = 16'd4;
    req1_rs2   = 16'd5;
    res_ready  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (res_valid) begin
        ids.push_back(int'(res_id));
        at.push_back(i);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chki("r039_count", ids.size(), 3);
    if (ids.size() == 3) begin
      chki("r039_id0", ids[0], 0);
      chki("r039_id1", ids[1], 1);
      chki("r039_id2", ids[2], 0);
      chki("r039_gap1", at[1] - at[0], 3);
      chki("r039_gap2", at[2] - at[1], 3);
    end
    res_ready = 1'b0;
    tick();

    // consumer stalls in HOLD
    req0_valid = 1'b1;
    req0_rs1   = 16'd11;
    req0_rs2   = 16'd13;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_rs1   = 16'd2;
    req1_rs2   = 16'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("r040_valid", res_valid, 1'b1);
      chkd("r040_data", res_data, 32'h0000008F);
      chk1("r040_id", res_id, 1'b0);
      chk1("r040_rdy0", req0_ready, 1'b0);
      chk1("r040_rdy1", req1_ready, 1'b0);
      tick();
    end
    res_ready = 1'b1;
    chk1("r040_last", res_valid, 1'b1);
    tick();
    chk1("r040_clr", res_valid, 1'b0);
    chkd("r040_keep", res_data, 32'h0000008F);
    chk1("r040_regrant", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    chkd("r040_next", res_data, 32'h00000004);
    tick();
    res_ready = 1'b0;

    // reset during CALC
    req0_valid = 1'b1;
    req0_rs1   = 16'd7;
    req0_rs2   = 16'd7;
    tick();
    req0_valid = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    chk1("r041_valid", res_valid, 1'b0);
    chkd("r041_data", res_data, '0);
    chk1("r041_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("r041_stale", res_valid, 1'b0);
    end

    // operands change after the handshake
    req0_valid = 1'b1;
    req0_rs1   = 16'd7;
    req0_rs2   = 16'd6;
    tick();
    req0_valid = 1'b0;
    req0_rs1   = 16'd9;
    req0_rs2   = 16'd2;
    tick();
    chkd("r042_data", res_data, 32'h0000002A);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      req0_valid = ($urandom_range(0, 99) < 70);
      req1_valid = ($urandom_range(0, 99) < 70);
      req0_rs1   = N'($urandom);
      req0_rs2   = N'($urandom);
      req1_rs1   = N'($urandom);
      req1_rs2   = N'($urandom);
      res_ready  = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: N, default 16, operand width of each multiplier input.
REQ-002 Derived width: result is 2*N bits; no other parameters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has operands pending.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req0_rs1  input  N  requester 0 multiplicand.
REQ-008 req0_rs2  input  N  requester 0 multiplier.
REQ-009 req1_valid  input  1  requester 1 has operands pending.
REQ-010 req1_ready  output  1  requester 1 operands accepted this cycle.
REQ-011 req1_rs1  input  N  requester 1 multiplicand.
REQ-012 req1_rs2  input  N  requester 1 multiplier.
REQ-013 res_valid  output  1  res_data/res_id hold a valid product.
REQ-014 res_ready  input  1  consumer accepts the result.
REQ-015 res_id  output  1  index of the requester that owns res_data.
REQ-016 res_data  output  2N  unsigned product rs1*rs2, full width.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 Block SHALL share one instance of the team's combinational N-bit unsigned multiplier (2N-bit product) between two requesters.
REQ-019 FSM states SHALL be IDLE, CALC, HOLD; no other states.
REQ-020 IDLE: if neither valid, SHALL remain IDLE with both ready low.
REQ-021 IDLE, one valid: SHALL assert that requester's ready combinationally in the same cycle.
REQ-022 IDLE, both valid: SHALL grant the requester not equal to last_grant; the other's ready stays low.
REQ-023 At most one reqX_ready SHALL be high in any cycle; both SHALL be low outside IDLE.
REQ-024 Handshake (valid & ready): SHALL capture rs1, rs2 into operand registers, store the granted index as pending id, set last_grant to that index, go to CALC.
REQ-025 CALC (one cycle): SHALL register the multiplier output into res_data and the pending id into res_id, set res_valid, go to HOLD.
REQ-026 Latency: handshake in cycle T SHALL give res_valid high from cycle T+2.
REQ-027 HOLD: res_valid, res_data, res_id SHALL stay stable until res_ready is sampled high.
REQ-028 HOLD with res_ready high: SHALL clear res_valid next cycle and go to IDLE; res_data keeps its last value.
REQ-029 A new grant SHALL occur no earlier than the cycle after HOLD exits; peak throughput is one result per 3 cycles.
REQ-030 res_ready high outside HOLD SHALL have no effect.
REQ-031 Requester valid dropped before ready SHALL cause no capture and no last_grant change.
REQ-032 Product SHALL be exact: res_data = rs1 * rs2 zero-extended to 2N bits, no truncation or saturation.
REQ-033 Operand inputs changing after the handshake SHALL not affect the in-flight result.

Reset
REQ-034 rst high at a rising edge SHALL force state IDLE, res_valid 0, res_data 0, res_id 0, operand registers 0, last_grant 1 (req0 wins first tie).
REQ-035 Reset in CALC or HOLD SHALL discard the in-flight result; no res_valid pulse after reset releases.
REQ-036 While rst is high, req0_ready, req1_ready and busy SHALL be low.

Verification
REQ-037 After reset, req0 valid with rs1=3, rs2=5 -> req0_ready same cycle; res_valid at T+2 with res_data=0x0000000F, res_id=0.
REQ-038 req1 only, rs1=0xFFFF, rs2=0xFFFF -> res_data=0xFFFE0001, res_id=1, exact full width.
REQ-039 Both valid from reset and held, res_ready tied high -> grants req0, then req1, then req0; res_id sequence 0,1,0, each 3 cycles apart.
REQ-040 res_ready held low 5 cycles in HOLD -> res_valid/res_data/res_id unchanged all 5 cycles; both ready low; result accepted on cycle res_ready rises.
REQ-041 rst pulsed during CALC -> next cycle state IDLE, res_valid 0, res_data 0, busy 0; no stale result appears.
REQ-042 Operands changed the cycle after handshake (rs1 7->9, rs2 6->2) -> res_data=0x0000002A (7*6).
